lru_victim_proc_md: RTL and testbench

LRU_VICTIM_PROC_MD -- requirements
Module: lru_victim_proc_md

---
 rtl/lru_victim_proc_md.sv | 115 +++++++++++
 tb/tb_lru_victim_proc_md.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lru_victim_proc_md.sv
// Tree pseudo-LRU replacement for a set-associative cache: one-cycle lookup of
// the hit way or the victim way, holding the set until the missed line is filled.
module lru_victim_proc_md #(
    parameter int ASSOC     = 8,
    parameter int ASSOC_WID = 3,
    parameter int INDEX_WID = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_rd,
    input  logic                 cmd_wr,
    input  logic [INDEX_WID-1:0] index_proc,
    input  logic [ASSOC-1:0]     access_blk_proc,
    input  logic [ASSOC-1:0]     invalid_blk_proc,
    input  logic                 fill_done,
    input  logic [ASSOC_WID-1:0] fill_way,
    output logic                 busy,
    output logic                 rsp_valid,
    output logic                 hit,
    output logic [ASSOC_WID-1:0] hit_way,
    output logic [ASSOC_WID-1:0] victim_way,
    output logic                 multi_hit_err
);
    localparam int NUM_SETS = 2**INDEX_WID;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS_WAIT} state_t;

    state_t               state, state_nxt;
    logic [INDEX_WID-1:0] idx_q;
    logic [ASSOC-1:0]     match_q, inv_q;
    logic [ASSOC-2:0]     tree [NUM_SETS];
    logic                 cmd, lookup, any_match;
    logic [ASSOC_WID-1:0] hit_enc, victim_enc;

    function automatic logic [ASSOC_WID-1:0] lowest(input logic [ASSOC-1:0] v);
        lowest = '0;
        for (int i = ASSOC-1; i >= 0; i--)
            if (v[i]) lowest = i[ASSOC_WID-1:0];
    endfunction

    // Walk root to leaf; a 0 bit steers toward the lower child (2n+1).
    function automatic logic [ASSOC_WID-1:0] tree_victim(input logic [ASSOC-2:0] t);
        int n;
        n = 0;
        tree_victim = '0;
        for (int l = ASSOC_WID-1; l >= 0; l--) begin
            tree_victim[l] = t[n[ASSOC_WID-1:0]];
            n = 2*n + 1 + int'(t[n[ASSOC_WID-1:0]]);
        end
    endfunction

    // Every node on w's path is pointed at the sibling subtree of w.
    function automatic logic [ASSOC-2:0] tree_update(input logic [ASSOC-2:0] t,
                                                     input logic [ASSOC_WID-1:0] w);
        int n;
        n = 0;
        tree_update = t;
        for (int l = ASSOC_WID-1; l >= 0; l--) begin
            tree_update[n[ASSOC_WID-1:0]] = ~w[l];
            n = 2*n + 1 + int'(w[l]);
        end
    endfunction

    assign cmd       = cmd_rd | cmd_wr;
    assign lookup    = (state == LOOKUP);
    assign any_match = |match_q;
    assign hit_enc   = lowest(match_q);
    assign victim_enc = (|inv_q) ? lowest(inv_q) : tree_victim(tree[idx_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (cmd) state_nxt = LOOKUP;
            LOOKUP:    state_nxt = any_match ? IDLE : MISS_WAIT;
            MISS_WAIT: if (fill_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            match_q <= '0;
            inv_q   <= '0;
        end else if (state == IDLE && cmd) begin
            idx_q   <= index_proc;
            match_q <= access_blk_proc;
            inv_q   <= invalid_blk_proc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) tree[s] <= '0;
        end else if (lookup && any_match) begin
            tree[idx_q] <= tree_update(tree[idx_q], hit_enc);
        end else if (state == MISS_WAIT && fill_done) begin
            tree[idx_q] <= tree_update(tree[idx_q], fill_way);
        end
    end

    // Outputs decode from state so reset clears them without waiting for a clock.
    assign busy          = (state != IDLE);
    assign rsp_valid     = lookup;
    assign hit           = lookup & any_match;
    assign hit_way       = (lookup & any_match) ? hit_enc : '0;
    assign victim_way    = (lookup & ~any_match) ? victim_enc : '0;
    assign multi_hit_err = lookup & (|(match_q & (match_q - ASSOC'(1))));

endmodule

// File: tb/tb_lru_victim_proc_md.sv
// Directed bench for lru_victim_proc_md: hits, misses, fills, busy handling and reset.
module tb_lru_victim_proc_md;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_rd = 1'b0, cmd_wr = 1'b0;
    logic [5:0] index_proc = '0;
    logic [7:0] access_blk_proc = '0, invalid_blk_proc = '0;
    logic       fill_done = 1'b0;
    logic [2:0] fill_way = '0;
    logic       busy, rsp_valid, hit, multi_hit_err;
    logic [2:0] hit_way, victim_way;

    int errors = 0;
    int checks = 0;

    lru_victim_proc_md #(.ASSOC(8), .ASSOC_WID(3), .INDEX_WID(6)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
        .index_proc(index_proc), .access_blk_proc(access_blk_proc),
        .invalid_blk_proc(invalid_blk_proc), .fill_done(fill_done), .fill_way(fill_way),
        .busy(busy), .rsp_valid(rsp_valid), .hit(hit), .hit_way(hit_way),
        .victim_way(victim_way), .multi_hit_err(multi_hit_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; returns with the DUT in LOOKUP.
    task automatic issue(input logic rd, input logic wr, input logic [5:0] idx,
                         input logic [7:0] m, input logic [7:0] inv);
        cmd_rd = rd; cmd_wr = wr; index_proc = idx;
        access_blk_proc = m; invalid_blk_proc = inv;
        step();
        cmd_rd = 1'b0; cmd_wr = 1'b0; access_blk_proc = '0; invalid_blk_proc = '0;
    endtask

    task automatic fill(input logic [2:0] w);
        fill_done = 1'b1; fill_way = w;
        step();
        fill_done = 1'b0; fill_way = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({rsp_valid, hit, multi_hit_err, hit_way, victim_way} !== 9'b0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0",
                               {rsp_valid, hit, multi_hit_err, hit_way, victim_way}); end
        rst_n = 1'b1;
    endtask

    task automatic test_miss_fill();
        issue(1'b1, 1'b0, 6'd5, 8'h00, 8'h00);
        checks++; if ({rsp_valid, hit, busy, victim_way} !== {3'b101, 3'd0}) begin
            errors++; $display("FAIL miss5_lookup got=%b exp=%b", {rsp_valid, hit, busy, victim_way}, {3'b101, 3'd0}); end
        step();
        checks++; if ({rsp_valid, busy} !== 2'b01) begin
            errors++; $display("FAIL miss5_wait got=%b exp=01", {rsp_valid, busy}); end
        fill(3'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill5_idle got=%b exp=0", busy); end
        // Set 5 tree bits 0,1,3 set: victim walks upper, lower, lower -> way 4.
        issue(1'b1, 1'b0, 6'd5, 8'h00, 8'h00);
        checks++; if ({hit, victim_way} !== {1'b0, 3'd4}) begin
            errors++; $display("FAIL miss5_tree got=%b exp=%b", {hit, victim_way}, {1'b0, 3'd4}); end
        step();
        fill(3'd4);
    endtask

    task automatic test_hit();
        issue(1'b0, 1'b1, 6'd2, 8'h10, 8'h00);
        checks++; if ({rsp_valid, hit, hit_way, multi_hit_err, victim_way} !== {2'b11, 3'd4, 1'b0, 3'd0}) begin
            errors++; $display("FAIL hit2_way4 got=%b exp=%b", {rsp_valid, hit, hit_way, multi_hit_err, victim_way},
                               {2'b11, 3'd4, 1'b0, 3'd0}); end
        step();
        checks++; if ({busy, rsp_valid, hit, hit_way} !== 6'b0) begin
            errors++; $display("FAIL hit2_done got=%b exp=0", {busy, rsp_valid, hit, hit_way}); end
        // rd and wr together count as a single request.
        issue(1'b1, 1'b1, 6'd2, 8'h01, 8'h00);
        checks++; if ({hit, hit_way} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL hit2_way0 got=%b exp=%b", {hit, hit_way}, {1'b1, 3'd0}); end
        step();
        // Set 2 bits 0,1,2,3,5 set -> victim upper, upper, lower -> way 6.
        issue(1'b1, 1'b0, 6'd2, 8'h00, 8'h00);
        checks++; if ({hit, victim_way} !== {1'b0, 3'd6}) begin
            errors++; $display("FAIL miss2_tree got=%b exp=%b", {hit, victim_way}, {1'b0, 3'd6}); end
        step();
        fill(3'd6);
    endtask

    task automatic test_invalid();
        issue(1'b1, 1'b0, 6'd7, 8'h00, 8'h44);
        checks++; if (victim_way !== 3'd2) begin errors++; $display("FAIL inv7 got=%0d exp=2", victim_way); end
        step();
        fill(3'd2);
        // Set 5 tree victim is way 2 here; invalid flag must override it.
        issue(1'b1, 1'b0, 6'd5, 8'h00, 8'h80);
        checks++; if (victim_way !== 3'd7) begin errors++; $display("FAIL inv5 got=%0d exp=7", victim_way); end
        step();
        fill(3'd7);
    endtask

    task automatic test_multi_hit();
        issue(1'b1, 1'b0, 6'd3, 8'h82, 8'h00);
        checks++; if ({hit, hit_way, multi_hit_err} !== {1'b1, 3'd1, 1'b1}) begin
            errors++; $display("FAIL multi_hit got=%b exp=%b", {hit, hit_way, multi_hit_err}, {1'b1, 3'd1, 1'b1}); end
        step();
        checks++; if ({multi_hit_err, busy} !== 2'b00) begin
            errors++; $display("FAIL multi_hit_pulse got=%b exp=00", {multi_hit_err, busy}); end
    endtask

    task automatic test_busy_ignore();
        cmd_rd = 1'b1; index_proc = 6'd9;
        step();
        cmd_rd = 1'b0;
        // fill_done during LOOKUP must not end the miss.
        fill_done = 1'b1; fill_way = 3'd4;
        step();
        fill_done = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_in_lookup got=%b exp=1", busy); end
        issue(1'b1, 1'b0, 6'd9, 8'h10, 8'h00);
        checks++; if ({rsp_valid, busy} !== 2'b01) begin
            errors++; $display("FAIL cmd_while_busy got=%b exp=01", {rsp_valid, busy}); end
        fill(3'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill9_idle got=%b exp=0", busy); end
        fill(3'd4);
        issue(1'b1, 1'b0, 6'd9, 8'h00, 8'h00);
        checks++; if (victim_way !== 3'd4) begin errors++; $display("FAIL fill_in_idle got=%0d exp=4", victim_way); end
        step();
        fill(3'd4);
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, 6'd11, 8'h01, 8'h00);
        step();
        issue(1'b1, 1'b0, 6'd11, 8'h00, 8'h00);
        checks++; if (victim_way !== 3'd4) begin errors++; $display("FAIL pre_reset11 got=%0d exp=4", victim_way); end
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
        step();
        #2 rst_n = 1'b1;
        step();
        checks++; if ({busy, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_abandon got=%b exp=00", {busy, rsp_valid}); end
        issue(1'b1, 1'b0, 6'd11, 8'h00, 8'h00);
        checks++; if ({rsp_valid, victim_way} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL post_reset11 got=%b exp=%b", {rsp_valid, victim_way}, {1'b1, 3'd0}); end
        step();
        fill(3'd0);
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_invalid();
        test_multi_hit();
        test_busy_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
